// File: rtl/psw_store.sv
// Password store: keypad digit capture plus two BCD shift registers (mem, buff)
// with length counters and combinational match/limit flags.
module psw_store #(
  parameter int unsigned MAX_DIGITS = 8,
  parameter int unsigned MASTER_LEN = 6,
  parameter logic [4*MASTER_LEN-1:0] MASTER_PSW = 24'h142857,
  localparam int unsigned LenW = $clog2(MAX_DIGITS + 1)
) (
  input  logic            clk,
  input  logic            nreset_i,
  input  logic            key_pressed_i,
  input  logic [3:0]      key_digit_i,
  input  logic            write_to_mem_i,
  input  logic            input_rst_i,
  input  logic            input_sl_i,
  output logic            input_valid_o,
  output logic            same_o,
  output logic            master_same_o,
  output logic            mem_limit_o,
  output logic            buff_limit_o,
  output logic [LenW-1:0] mem_len_o,
  output logic [LenW-1:0] buff_len_o
);

  localparam int unsigned RegW = 4 * MAX_DIGITS;
  localparam logic [LenW-1:0] MaxLen = LenW'(MAX_DIGITS);
  localparam logic [LenW-1:0] MasterLen = LenW'(MASTER_LEN);

  logic            sync1_q, sync2_q, prev_q;
  logic [1:0]      live_q;
  logic            armed_q;
  logic            valid_q;
  logic [3:0]      pend_q;
  logic            key_rise;
  logic            digit_ok;

  logic [RegW-1:0] mem_q, mem_d, buff_q, buff_d;
  logic [LenW-1:0] mem_len_q, mem_len_d, buff_len_q, buff_len_d;

  // live_q marks when sync2_q carries a real post-reset sample; armed_q is set
  // only once the key has been seen low, so a key held through reset is ignored.
  assign key_rise = sync2_q & ~prev_q & armed_q;
  assign digit_ok = (key_digit_i <= 4'd9);

  // Keypad synchronizer, edge detector and pending digit.
  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      live_q  <= 2'b00;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      pend_q  <= 4'd0;
    end else begin
      sync1_q <= key_pressed_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      live_q  <= {live_q[0], 1'b1};
      armed_q <= armed_q | (live_q[1] & ~sync2_q);
      valid_q <= key_rise & digit_ok;
      if (key_rise && digit_ok) begin
        pend_q <= key_digit_i;
      end
    end
  end

  // Next-state for the selected register; reset wins over shift.
  always_comb begin
    mem_d      = mem_q;
    mem_len_d  = mem_len_q;
    buff_d     = buff_q;
    buff_len_d = buff_len_q;
    if (write_to_mem_i) begin
      if (input_rst_i) begin
        mem_d     = '0;
        mem_len_d = '0;
      end else if (input_sl_i && (mem_len_q != MaxLen)) begin
        mem_d     = {mem_q[RegW-5:0], pend_q};
        mem_len_d = mem_len_q + 1'b1;
      end
    end else begin
      if (input_rst_i) begin
        buff_d     = '0;
        buff_len_d = '0;
      end else if (input_sl_i && (buff_len_q != MaxLen)) begin
        buff_d     = {buff_q[RegW-5:0], pend_q};
        buff_len_d = buff_len_q + 1'b1;
      end
    end
  end

  // Password register state.
  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      mem_q      <= '0;
      mem_len_q  <= '0;
      buff_q     <= '0;
      buff_len_q <= '0;
    end else begin
      mem_q      <= mem_d;
      mem_len_q  <= mem_len_d;
      buff_q     <= buff_d;
      buff_len_q <= buff_len_d;
    end
  end

  // Match over the low mem_len digits only; an empty mem never matches.
  always_comb begin
    same_o = (mem_len_q == buff_len_q) && (mem_len_q != '0);
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if ((i < 32'(mem_len_q)) && (mem_q[4*i +: 4] != buff_q[4*i +: 4])) begin
        same_o = 1'b0;
      end
    end
  end

  assign master_same_o = (buff_len_q == MasterLen) &&
                         (buff_q[4*MASTER_LEN-1:0] == MASTER_PSW);
  assign mem_limit_o   = (mem_len_q == MaxLen);
  assign buff_limit_o  = (buff_len_q == MaxLen);
  assign mem_len_o     = mem_len_q;
  assign buff_len_o    = buff_len_q;
  assign input_valid_o = valid_q;

endmodule

// File: tb/tb_psw_store.sv
// Randomized self-checking bench for psw_store against a digit-queue model.
module tb_psw_store;

  localparam int MaxDigits = 8;

  logic       clk;
  logic       nreset_i;
  logic       key_pressed_i;
  logic [3:0] key_digit_i;
  logic       write_to_mem_i;
  logic       input_rst_i;
  logic       input_sl_i;
  logic       input_valid_o;
  logic       same_o;
  logic       master_same_o;
  logic       mem_limit_o;
  logic       buff_limit_o;
  logic [3:0] mem_len_o;
  logic [3:0] buff_len_o;

  psw_store dut (
    .clk            (clk),
    .nreset_i       (nreset_i),
    .key_pressed_i  (key_pressed_i),
    .key_digit_i    (key_digit_i),
    .write_to_mem_i (write_to_mem_i),
    .input_rst_i    (input_rst_i),
    .input_sl_i     (input_sl_i),
    .input_valid_o  (input_valid_o),
    .same_o         (same_o),
    .master_same_o  (master_same_o),
    .mem_limit_o    (mem_limit_o),
    .buff_limit_o   (buff_limit_o),
    .mem_len_o      (mem_len_o),
    .buff_len_o     (buff_len_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: registers as digit queues, oldest digit first.
  int mq[$];
  int bq[$];
  int pend = 0;
  int master_digits[6] = '{1, 4, 2, 8, 5, 7};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_same();
    if (mq.size() != bq.size() || mq.size() == 0) return 0;
    foreach (mq[i]) if (mq[i] != bq[i]) return 0;
    return 1;
  endfunction

  function automatic int exp_master();
    if (bq.size() != 6) return 0;
    foreach (bq[i]) if (bq[i] != master_digits[i]) return 0;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, " mem_len"}, 32'(mem_len_o), mq.size());
    check_eq({tag, " buff_len"}, 32'(buff_len_o), bq.size());
    check_eq({tag, " mem_limit"}, 32'(mem_limit_o), (mq.size() == MaxDigits) ? 1 : 0);
    check_eq({tag, " buff_limit"}, 32'(buff_limit_o), (bq.size() == MaxDigits) ? 1 : 0);
    check_eq({tag, " same"}, 32'(same_o), exp_same());
    check_eq({tag, " master_same"}, 32'(master_same_o), exp_master());
    check_eq({tag, " valid_idle"}, 32'(input_valid_o), 0);
  endtask

  // Press a key for hold cycles, release, and check pulse count and latency.
  task automatic press(input int d, input int hold, input string tag);
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    key_digit_i   = 4'(d);
    key_pressed_i = 1'b1;
    for (int c = 1; c <= hold; c++) begin
      tick();
      if (input_valid_o) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    key_pressed_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (input_valid_o) pulses++;
    end
    check_eq({tag, " pulses"}, pulses, (d <= 9) ? 1 : 0);
    if (d <= 9) begin
      check_eq({tag, " latency"}, first, 3);
      pend = d;
    end
  endtask

  task automatic op(input bit wm, input bit sl, input bit rst, input string tag);
    write_to_mem_i = wm;
    input_sl_i     = sl;
    input_rst_i    = rst;
    tick();
    input_sl_i  = 1'b0;
    input_rst_i = 1'b0;
    if (rst) begin
      if (wm) mq.delete(); else bq.delete();
    end else if (sl) begin
      if (wm) begin
        if (mq.size() < MaxDigits) mq.push_back(pend);
      end else begin
        if (bq.size() < MaxDigits) bq.push_back(pend);
      end
    end
    check_all(tag);
  endtask

  task automatic enter(input bit wm, input int ds[$], input string tag);
    foreach (ds[i]) begin
      press(ds[i], 4, tag);
      op(wm, 1'b1, 1'b0, tag);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    nreset_i       = 1'b0;
    key_pressed_i  = 1'b0;
    key_digit_i    = 4'd0;
    write_to_mem_i = 1'b0;
    input_rst_i    = 1'b0;
    input_sl_i     = 1'b0;
    repeat (3) tick();
    check_all("reset");
    nreset_i = 1'b1;
    repeat (5) tick();
    check_all("post_reset");

    enter(1'b1, '{1, 2, 3, 4}, "mem1234");
    check_eq("mem1234 len", 32'(mem_len_o), 4);
    check_eq("mem1234 same", 32'(same_o), 0);
    enter(1'b0, '{1, 2, 3, 4}, "buff1234");
    check_eq("buff1234 same", 32'(same_o), 1);
    enter(1'b0, '{5}, "buff5th");
    check_eq("buff5th same", 32'(same_o), 0);
    op(1'b0, 1'b0, 1'b1, "buff_rst");
    check_eq("buff_rst len", 32'(buff_len_o), 0);

    enter(1'b0, '{1, 4, 2, 8, 5, 7}, "master");
    check_eq("master hit", 32'(master_same_o), 1);
    enter(1'b0, '{3}, "master7th");
    check_eq("master7th miss", 32'(master_same_o), 0);
    op(1'b0, 1'b0, 1'b1, "buff_rst2");

    op(1'b1, 1'b0, 1'b1, "mem_rst");
    enter(1'b1, '{9, 8, 7, 6, 5, 4, 3, 2}, "mem8");
    check_eq("mem8 limit", 32'(mem_limit_o), 1);
    press(1, 4, "mem9");
    op(1'b1, 1'b1, 1'b0, "mem9 shift");
    check_eq("mem9 len", 32'(mem_len_o), 8);
    enter(1'b0, '{9, 8, 7, 6, 5, 4, 3, 2}, "buff8");
    check_eq("mem9 contents", 32'(same_o), 1);

    press(5, 20, "hold20");
    press(10, 5, "digitA");
    op(1'b1, 1'b1, 1'b1, "rst_and_sl");
    check_eq("rst_and_sl len", 32'(mem_len_o), 0);

    // Random mix of presses (incl. invalid codes) and register operations.
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        press($urandom_range(0, 15), $urandom_range(3, 8), "rnd_press");
      end else if (r < 8) begin
        op(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 5) == 0), "rnd_sl");
      end else begin
        op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, "rnd_rst");
      end
    end

    // Reset mid-entry with the key held down.
    enter(1'b1, '{4, 5}, "pre_rst");
    key_digit_i   = 4'd3;
    key_pressed_i = 1'b1;
    tick();
    #2;
    nreset_i = 1'b0;
    #1;
    mq.delete();
    bq.delete();
    pend = 0;
    check_all("mid_reset");
    repeat (2) tick();
    nreset_i = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (input_valid_o) pulses++;
    end
    check_eq("held_through_reset pulses", pulses, 0);
    check_all("after_reset");
    key_pressed_i = 1'b0;
    repeat (4) tick();
    press(6, 4, "repress");
    op(1'b0, 1'b1, 1'b0, "repress shift");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
